ma_sample_feeder: RTL and testbench

MA_SAMPLE_FEEDER -- requirements
Module: ma_sample_feeder

---
 rtl/ma_sample_feeder.sv | 127 ++++++++++++
 tb/tb_ma_sample_feeder.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/ma_sample_feeder.sv
// rtl/ma_sample_feeder.sv - sample FIFO feeding a strobe/ack averager and capturing its result
// One sample in flight at a time; sticky errors flag FIFO overflow and a missing averager ack.
module ma_sample_feeder #(
    parameter int DATA_W     = 10,
    parameter int FIFO_POWER = 3,
    parameter int TIMEOUT    = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  clr_err,
    output logic                  fifo_full,
    output logic                  fifo_empty,
    output logic [FIFO_POWER:0]   fifo_count,
    output logic [DATA_W-1:0]     sample_o,
    output logic                  strobe_o,
    input  logic [DATA_W-1:0]     avg_i,
    input  logic                  avg_strobe_i,
    output logic [DATA_W-1:0]     result_o,
    output logic                  result_valid,
    output logic                  busy,
    output logic                  overflow_err,
    output logic                  timeout_err
);

    localparam int DEPTH = 1 << FIFO_POWER;
    localparam int CNT_W = $clog2(TIMEOUT) + 1;

    typedef enum logic [1:0] {
        IDLE,
        STROBE,
        WAIT_ACK,
        CAPTURE
    } state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [DATA_W-1:0]      mem [DEPTH];
    logic [FIFO_POWER-1:0]  wr_ptr;
    logic [FIFO_POWER-1:0]  rd_ptr;
    logic [FIFO_POWER:0]    count;
    logic [CNT_W-1:0]       wait_cnt;
    logic                   pop;
    logic                   push;
    logic                   ovf_set;
    logic                   tmo_set;

    assign fifo_count = count;
    assign fifo_full  = (count == (FIFO_POWER+1)'(DEPTH));
    assign fifo_empty = (count == '0);
    assign strobe_o   = (state == STROBE);
    assign busy       = (state != IDLE);

    // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
    assign pop     = (state == IDLE) && !fifo_empty;
    assign push    = wr_en && (!fifo_full || pop);
    assign ovf_set = wr_en && fifo_full && !pop;

    always_comb begin
        state_nx = state;
        tmo_set  = 1'b0;
        unique case (state)
            IDLE:     if (pop) state_nx = STROBE;
            STROBE:   state_nx = WAIT_ACK;
            WAIT_ACK: begin
                if (avg_strobe_i) begin
                    state_nx = CAPTURE;
                end else if (wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    tmo_set  = 1'b1;
                    state_nx = IDLE;
                end
            end
            CAPTURE:  state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push && !reset) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            wait_cnt     <= '0;
            sample_o     <= '0;
            result_o     <= '0;
            result_valid <= 1'b0;
            overflow_err <= 1'b0;
            timeout_err  <= 1'b0;
        end else begin
            state <= state_nx;
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) begin
                rd_ptr   <= rd_ptr + 1'b1;
                sample_o <= mem[rd_ptr];
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase

            if (state == STROBE) begin
                wait_cnt <= '0;
            end else if (state == WAIT_ACK && !avg_strobe_i) begin
                wait_cnt <= wait_cnt + 1'b1;
            end

            // The averager presents its result the cycle after its strobe.
            result_valid <= (state == CAPTURE);
            if (state == CAPTURE) result_o <= avg_i;

            if (ovf_set)      overflow_err <= 1'b1;
            else if (clr_err) overflow_err <= 1'b0;
            if (tmo_set)      timeout_err  <= 1'b1;
            else if (clr_err) timeout_err  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ma_sample_feeder.sv
// tb/tb_ma_sample_feeder.sv - randomized bench for ma_sample_feeder against a transaction-level model
module tb_ma_sample_feeder;

    localparam int DATA_W     = 10;
    localparam int FIFO_POWER = 3;
    localparam int TIMEOUT    = 32;
    localparam int DEPTH      = 1 << FIFO_POWER;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                wr_en = 1'b0;
    logic [DATA_W-1:0]   wr_data = '0;
    logic                clr_err = 1'b0;
    logic                fifo_full;
    logic                fifo_empty;
    logic [FIFO_POWER:0] fifo_count;
    logic [DATA_W-1:0]   sample_o;
    logic                strobe_o;
    logic [DATA_W-1:0]   avg_i = '0;
    logic                avg_strobe_i = 1'b0;
    logic [DATA_W-1:0]   result_o;
    logic                result_valid;
    logic                busy;
    logic                overflow_err;
    logic                timeout_err;

    ma_sample_feeder #(.DATA_W(DATA_W), .FIFO_POWER(FIFO_POWER), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data), .clr_err(clr_err),
        .fifo_full(fifo_full), .fifo_empty(fifo_empty), .fifo_count(fifo_count),
        .sample_o(sample_o), .strobe_o(strobe_o), .avg_i(avg_i), .avg_strobe_i(avg_strobe_i),
        .result_o(result_o), .result_valid(result_valid), .busy(busy),
        .overflow_err(overflow_err), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Model: age counts cycles since the sample left the queue (0 = no transaction);
    // age 1 is the strobe cycle, later ages are spent waiting until the ack, then one capture cycle.
    logic [DATA_W-1:0] q[$];
    int                age = 0;
    bit                m_cap = 0;
    int                ack_at = 0;
    logic [DATA_W-1:0] m_sample = '0, m_result = '0;
    bit                m_rv = 0, m_ovf = 0, m_tmo = 0;

    bit                ack_rand = 0;
    int                ack_fixed = 0;
    bit                spur = 0;
    bit                avg_fix_en = 0;
    logic [DATA_W-1:0] avg_fix = '0;
    int                n_strobe = 0, n_rv = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_step(input bit w, input logic [DATA_W-1:0] d, input bit c, input bit r,
                              input bit as, input logic [DATA_W-1:0] av);
        bit pop, full, waiting, ovf_set, tmo_set;
        if (r) begin
            q.delete();
            age = 0; m_cap = 0; m_sample = '0; m_result = '0;
            m_rv = 0; m_ovf = 0; m_tmo = 0;
        end else begin
            pop     = (age == 0) && (q.size() != 0);
            full    = (q.size() == DEPTH);
            waiting = (age >= 2) && !m_cap;
            ovf_set = w && full && !pop;
            tmo_set = waiting && !as && (age - 2 == TIMEOUT - 1);
            m_rv = m_cap;
            if (m_cap) m_result = av;
            if (pop) begin
                m_sample = q.pop_front();
                age = 1;
                ack_at = ack_rand ? int'($urandom_range(2, 40)) : ack_fixed;
            end else if (m_cap) begin
                m_cap = 0; age = 0;
            end else if (waiting) begin
                if (as) m_cap = 1;
                else if (tmo_set) age = 0;
                else age++;
            end else if (age == 1) begin
                age = 2;
            end
            if (w && (!full || pop)) q.push_back(d);
            m_ovf = ovf_set ? 1'b1 : (c ? 1'b0 : m_ovf);
            m_tmo = tmo_set ? 1'b1 : (c ? 1'b0 : m_tmo);
        end
    endtask

    task automatic compare_all();
        check("fifo_count", 32'(fifo_count), 32'(q.size()));
        check("fifo_empty", 32'(fifo_empty), 32'(q.size() == 0));
        check("fifo_full", 32'(fifo_full), 32'(q.size() == DEPTH));
        check("sample_o", 32'(sample_o), 32'(m_sample));
        check("strobe_o", 32'(strobe_o), 32'(age == 1));
        check("result_o", 32'(result_o), 32'(m_result));
        check("result_valid", 32'(result_valid), 32'(m_rv));
        check("busy", 32'(busy), 32'(age != 0));
        check("overflow_err", 32'(overflow_err), 32'(m_ovf));
        check("timeout_err", 32'(timeout_err), 32'(m_tmo));
        if (strobe_o) n_strobe++;
        if (result_valid) n_rv++;
    endtask

    // Called at a falling edge: drive one cycle of inputs, advance the model, sample after the rise.
    task automatic step(input bit w, input logic [DATA_W-1:0] d, input bit c, input bit r);
        bit waiting, as;
        logic [DATA_W-1:0] av;
        waiting = (age >= 2) && !m_cap;
        as = (waiting && age == ack_at) || (spur && !waiting && $urandom_range(0, 3) == 0);
        av = avg_fix_en ? avg_fix : DATA_W'($urandom);
        wr_en = w; wr_data = d; clr_err = c; reset = r;
        avg_strobe_i = as; avg_i = av;
        model_step(w, d, c, r, as, av);
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    task automatic idle_cycles(input int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        @(negedge clk);
        // Reset held two cycles with a push request that must be ignored
        step(1'b1, 10'h3ff, 1'b0, 1'b1);
        step(1'b1, 10'h3ff, 1'b0, 1'b1);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);

        // Single sample, ack 17 cycles after the strobe
        ack_fixed = 18; avg_fix_en = 1; avg_fix = 10'h015;
        n_strobe = 0; n_rv = 0;
        step(1'b1, 10'h155, 1'b0, 1'b0);
        idle_cycles(25);
        check("single_strobes", 32'(n_strobe), 32'd1);
        check("single_results", 32'(n_rv), 32'd1);
        check("single_result", 32'(result_o), 32'h015);
        avg_fix_en = 0;

        // Overflow: ack withheld, nine pushes fill the FIFO, the tenth is dropped
        ack_fixed = 0;
        for (int i = 0; i < 9; i++) step(1'b1, DATA_W'(i + 1), 1'b0, 1'b0);
        check("ovf_full", 32'(fifo_full), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd8);
        step(1'b1, 10'h2aa, 1'b0, 1'b0);
        check("ovf_set", 32'(overflow_err), 32'd1);
        step(1'b0, '0, 1'b1, 1'b0);
        check("ovf_clr", 32'(overflow_err), 32'd0);
        // Simultaneous push and pop while full
        for (int i = 0; i < 60 && age != 0; i++) idle_cycles(1);
        check("sim_idle_full", 32'(q.size()), 32'(DEPTH));
        step(1'b1, 10'h111, 1'b0, 1'b0);
        check("sim_count", 32'(fifo_count), 32'd8);
        check("sim_ovf", 32'(overflow_err), 32'd0);

        // Timeout on a lone sample, then a following sample completes
        step(1'b0, '0, 1'b0, 1'b1);
        step(1'b1, 10'h0f0, 1'b1, 1'b0);
        idle_cycles(40);
        check("tmo_flag", 32'(timeout_err), 32'd1);
        check("tmo_busy", 32'(busy), 32'd0);
        ack_fixed = 5; n_rv = 0;
        step(1'b1, 10'h00f, 1'b0, 1'b0);
        idle_cycles(12);
        check("tmo_next_result", 32'(n_rv), 32'd1);

        // Reset while waiting with three samples queued
        ack_fixed = 0;
        for (int i = 0; i < 4; i++) step(1'b1, DATA_W'($urandom), 1'b0, 1'b0);
        idle_cycles(4);
        n_strobe = 0; n_rv = 0;
        step(1'b1, 10'h123, 1'b0, 1'b1);
        idle_cycles(10);
        check("midrst_count", 32'(fifo_count), 32'd0);
        check("midrst_strobes", 32'(n_strobe), 32'd0);
        check("midrst_results", 32'(n_rv), 32'd0);

        // Randomized traffic with spurious averager strobes and random ack latencies
        ack_rand = 1; spur = 1;
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 9) < 4), DATA_W'($urandom),
                 ($urandom_range(0, 19) == 0), ($urandom_range(0, 199) == 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
